// File: rtl/regfile_wb_arbiter_if.sv
// Write-back arbiter bus: requester handshake, decode-stage hazard query,
// register-file write port and the contention counter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 16
);
    logic [N-1:0]     req_valid;
    logic [5*N-1:0]   req_rd;
    logic [32*N-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic             hold;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             hz_rs1;
    logic             hz_rs2;
    logic             wr_en;
    logic [4:0]       rd;
    logic [31:0]      wr_data;
    logic [CNT_W-1:0] contention_cnt;

    modport slave (
        input  req_valid, req_rd, req_data, hold, rs1, rs2,
        output req_ready, hz_rs1, hz_rs2, wr_en, rd, wr_data, contention_cnt
    );

    modport master (
        output req_valid, req_rd, req_data, hold, rs1, rs2,
        input  req_ready, hz_rs1, hz_rs2, wr_en, rd, wr_data, contention_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port between N write-back
// requesters, with a one-deep registered write stage and RAW hazard flags.
module regfile_wb_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic             wb_valid_q, wb_valid_d;
    logic [4:0]       rd_q, rd_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]      rd_arr   [N];
    logic [31:0]     data_arr [N];
    logic [N-1:0]    grant;
    logic [PtrW-1:0] gnt_idx;
    logic            xfer;
    logic            hz1, hz2;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign rd_arr[i]   = bus.req_rd[5*i +: 5];
        assign data_arr[i] = bus.req_data[32*i +: 32];
    end

    // Scan starts at ptr_q and wraps; reset masks grants so nothing is accepted.
    always_comb begin
        logic [PtrW-1:0] idx;
        idx     = '0;
        grant   = '0;
        gnt_idx = '0;
        xfer    = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            idx = PtrW'((int'(ptr_q) + k) % int'(N));
            if (!rst && !bus.hold && !xfer && bus.req_valid[idx]) begin
                xfer       = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        wb_valid_d = 1'b0;
        rd_d       = rd_q;
        data_d     = data_q;
        if (xfer) begin
            ptr_d      = (gnt_idx == PtrW'(N - 1)) ? '0 : gnt_idx + PtrW'(1);
            wb_valid_d = (rd_arr[gnt_idx] != 5'd0);
            rd_d       = rd_arr[gnt_idx];
            data_d     = data_arr[gnt_idx];
        end
    end

    // Contention is counted on raw valids, independent of hold.
    always_comb begin
        int nvalid;
        nvalid = 0;
        for (int i = 0; i < int'(N); i++) begin
            nvalid += int'(bus.req_valid[i]);
        end
        cnt_d = cnt_q;
        if (nvalid >= 2 && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // The staged write still counts as pending until the edge that commits it.
    always_comb begin
        hz1 = wb_valid_q && (rd_q == bus.rs1);
        hz2 = wb_valid_q && (rd_q == bus.rs2);
        for (int i = 0; i < int'(N); i++) begin
            hz1 = hz1 | (bus.req_valid[i] && (rd_arr[i] == bus.rs1));
            hz2 = hz2 | (bus.req_valid[i] && (rd_arr[i] == bus.rs2));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            wb_valid_q <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
        end else begin
            ptr_q      <= ptr_d;
            wb_valid_q <= wb_valid_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.req_ready      = grant;
    assign bus.hz_rs1         = hz1 && (bus.rs1 != 5'd0);
    assign bus.hz_rs2         = hz2 && (bus.rs2 != 5'd0);
    assign bus.wr_en          = wb_valid_q;
    assign bus.rd             = rd_q;
    assign bus.wr_data        = data_q;
    assign bus.contention_cnt = cnt_q;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between N write-back requesters, for example the ALU, the load unit and the mul/div unit.
- Arbitrates round-robin and drives wr_en/rd/wr_data into the register file from a one-deep registered write-back stage.
- Flags read-after-write hazards on rs1/rs2 for pending writes, so the decode stage can stall.
- Counts contention cycles for performance debug.

Parameters:
- N, 3, number of write-back requesters (2..8).
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N  requester i has a write pending.
- req_rd  in  5*N  destination register of requester i, bits [5i+4:5i].
- req_data  in  32*N  write data of requester i, bits [32i+31:32i].
- req_ready  out  N  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high at a clock edge.
- hold  in  1  freeze arbitration (debug/stall); no grants while high.
- rs1  in  5  decode-stage source register 1.
- rs2  in  5  decode-stage source register 2.
- hz_rs1  out  1  rs1 has a write not yet committed.
- hz_rs2  out  1  rs2 has a write not yet committed.
- wr_en  out  1  register-file write enable.
- rd  out  5  register-file write address.
- wr_data  out  32  register-file write data.
- contention_cnt  out  CNT_W  saturating count of cycles with two or more req_valid high.

Behaviour:
- Reset (asynchronous, takes effect immediately): wb_valid=0, rd=0, wr_data=0, ptr=0, contention_cnt=0. req_ready is 0 during reset. Reset mid-transfer discards the staged write; no write-enable glitch reaches the register file.
- Grant (combinational): if hold=0, grant the first i with req_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. req_ready has exactly one bit set for the granted index and is all zero if no valid request or if hold=1. req_ready never depends on a ready from downstream, because the register file always accepts.
- Pointer: on a transfer, ptr <= (g+1) mod N. Otherwise ptr holds. Wrap-around is exercised when g=N-1, giving ptr=0.
- Write-back stage:
  - On a transfer: wb_valid <= (req_rd[g]!=0), rd <= req_rd[g], wr_data <= req_data[g].
  - With no transfer: wb_valid <= 0, and rd/wr_data hold.
  - wr_en = wb_valid.
  - Latency: exactly 1 cycle from the accepting edge to wr_en, and the register file captures on the next edge.
- Writes to x0 are accepted (ready, ptr advances) but never assert wr_en.
- Throughput: one write per cycle. Requesters must hold valid, rd and data stable until granted. Deasserting req_valid before grant is permitted and drops the request without side effects.
- hold=1: no grants; the stage still drains, so wb_valid falls to 0 on the next edge. The pending request keeps priority order on release.
- Hazard (combinational), for s in {rs1, rs2}: hz = (s!=0) & ((wb_valid & rd==s) | OR over i of (req_valid[i] & req_rd[i]==s)). A staged write is visible to a register-file read only after the edge where wr_en=1, so hz stays high during that cycle.
- contention_cnt: increments on every edge where popcount(req_valid)>=2, regardless of hold. It saturates at all-ones and does not wrap.
- Simultaneous requests to the same rd from different requesters are serialized in grant order, so the later grant's value is the final register content.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> all outputs 0 immediately; with req_valid=0 for 10 cycles, wr_en stays 0 and contention_cnt=0.
- Single requester: req_valid=3'b010, rd=7, data=0xDEADBEEF -> req_ready=3'b010 that cycle; next cycle wr_en=1, rd=7, wr_data=0xDEADBEEF; ptr=2.
- Round-robin: all three valid continuously with rd=1,2,3 -> grants 0,1,2,0,1,2 on consecutive cycles; wr_en high every cycle; contention_cnt increments each cycle.
- x0 drop and hold:
  - Requester 0 with rd=0 -> granted, but wr_en stays 0.
  - hold=1 with requester 1 valid -> req_ready=0; on release, requester 1 is granted first.
- Hazard: rs1=5 while requester 2 is pending with rd=5 -> hz_rs1=1 through the grant cycle and the wr_en cycle, then 0. rs2=0 with a pending rd=0 -> hz_rs2=0.
- Reset mid-operation and saturation:
  - Assert rst while wb_valid=1 -> wr_en drops immediately; no write occurs.
  - With CNT_W=4 and 20 contention cycles -> contention_cnt=15.
